// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: kernel geometry and the
// window element indexing used to pack and unpack 3x3 windows.
package cnn_pkg;

    localparam int KERNEL     = 3;
    localparam int CNN_DATA_W = 8;

    function automatic int win_idx(input int r, input int c);
        return r * KERNEL + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular-RAM delay line: dout is the sample written exactly DEPTH enables ago.
// Reads before writing at the same pointer, so one pointer serves both ports.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: turns a raster pixel stream into
// every fully populated valid-convolution window with its output coordinates.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [9*DATA_W-1:0]       win_data,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic                      frame_done
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic [ROW_W-1:0]   in_row;
    logic [COL_W-1:0]   in_col;
    logic               pix_acc;
    logic               row_last;
    logic               col_last;
    logic               win_done;
    logic [DATA_W-1:0]  line1_out;
    logic [DATA_W-1:0]  line2_out;
    logic [DATA_W-1:0]  new_col [KERNEL];
    logic [DATA_W-1:0]  hist    [KERNEL][KERNEL-1];
    logic [9*DATA_W-1:0] win_nxt;

    assign in_ready = !win_valid || win_ready;
    // clr wins over a same-cycle pixel: the pixel is neither counted nor stored.
    assign pix_acc  = in_valid && in_ready && !clr;
    assign row_last = (in_row == ROW_W'(IMG_H - 1));
    assign col_last = (in_col == COL_W'(IMG_W - 1));
    assign win_done = (in_row >= ROW_W'(2)) && (in_col >= COL_W'(2));

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_acc),
        .din   (in_data),
        .dout  (line1_out)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_acc),
        .din   (line1_out),
        .dout  (line2_out)
    );

    // Row 0 is the oldest line, row 2 the pixel arriving now.
    always_comb begin
        new_col[0] = line2_out;
        new_col[1] = line1_out;
        new_col[2] = in_data;
    end

    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_nxt[win_idx(r, c)*DATA_W +: DATA_W] = hist[r][c];
            end
            win_nxt[win_idx(r, KERNEL - 1)*DATA_W +: DATA_W] = new_col[r];
        end
    end

    // Two most recent columns; together with new_col they form the window.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            for (int r = 0; r < KERNEL; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_row     <= '0;
            in_col     <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_acc && row_last && col_last;
            if (clr) begin
                in_row    <= '0;
                in_col    <= '0;
                win_valid <= 1'b0;
            end else begin
                if (pix_acc) begin
                    if (col_last) begin
                        in_col <= '0;
                        in_row <= row_last ? '0 : in_row + 1'b1;
                    end else begin
                        in_col <= in_col + 1'b1;
                    end
                end
                if (pix_acc && win_done) begin
                    win_valid <= 1'b1;
                    win_data  <= win_nxt;
                    win_row   <= in_row - ROW_W'(2);
                    win_col   <= in_col - COL_W'(2);
                end else if (win_ready) begin
                    win_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a frame-array reference model predicts
// windows and frame_done; separate monitors compare what the DUTs present.
module tb_conv_window_gen;

    typedef struct {
        logic [71:0] data;
        int          row;
        int          col;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        clr = 1'b0, in_valid = 1'b0, win_ready = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, win_valid, frame_done;
    logic [71:0] win_data;
    logic [1:0]  win_row, win_col;

    logic        clr_b = 1'b0, in_valid_b = 1'b0, win_ready_b = 1'b1;
    logic [7:0]  in_data_b = 8'd0;
    logic        in_ready_b, win_valid_b, frame_done_b;
    logic [71:0] win_data_b;
    logic [1:0]  win_row_b, win_col_b;

    conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
    );

    conv_window_gen #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b), .win_data(win_data_b),
        .win_row(win_row_b), .win_col(win_col_b), .frame_done(frame_done_b)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    win_t sb_q[$];
    win_t sb_b[$];

    logic [7:0] frame [4][4];
    int   mr = 0, mc = 0;
    int   rdy_mode = 0;
    int   cyc = 0;
    logic acc_last = 1'b0;
    logic fd_prev = 1'b0;
    logic stall_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: store the pixel at its raster position; a window exists when
    // the 3x3 block ending here lies inside the frame.
    task automatic model_push(input logic [7:0] v);
        win_t w;
        frame[mr][mc] = v;
        acc_last = (mr == 3 && mc == 3);
        if (mr >= 2 && mc >= 2) begin
            w.data = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w.data[(r*3+c)*8 +: 8] = frame[mr-2+r][mc-2+c];
            w.row = mr - 2;
            w.col = mc - 2;
            sb_q.push_back(w);
        end
        if (mc == 3) begin
            mc = 0;
            mr = (mr == 3) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c, output logic acc);
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = cyc[0];
            2:       win_ready = 1'($urandom_range(0, 1));
            default: win_ready = 1'b0;
        endcase
        in_valid = v;
        in_data  = d;
        clr      = c;
        #1;
        acc_last = 1'b0;
        acc = v && in_ready && !c;
        if (c) begin
            mr = 0;
            mc = 0;
        end else if (acc) begin
            model_push(d);
        end
    endtask

    task automatic send(input logic [7:0] d);
        logic acc;
        int   guard = 0;
        do begin
            step(1'b1, d, 1'b0, acc);
            guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("send_timeout", 128'(acc), 128'(1'b1));
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, 8'd0, 1'b0, acc);
    endtask

    task automatic send_frame(input int base, input logic rnd);
        for (int i = 0; i < 16; i++)
            send(rnd ? 8'($urandom_range(0, 255)) : 8'(base + i));
    endtask

    task automatic drain();
        int guard = 0;
        rdy_mode = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        idle(2);
        chk("a_leftover_windows", 128'(sb_q.size()), 128'(0));
    endtask

    // Monitor for the 4x4 instance.
    initial begin
        logic [71:0] hd;
        logic [3:0]  hrc;
        win_t        w;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                chk("frame_done", 128'(frame_done), 128'(fd_prev));
                fd_prev = acc_last;
                if (stall_prev) begin
                    chk("stall_data_hold", 128'(win_data), 128'(hd));
                    chk("stall_coord_hold", 128'({win_row, win_col}), 128'(hrc));
                end
                stall_prev = 1'b0;
                if (win_valid && !win_ready) begin
                    chk("in_ready_stall", 128'(in_ready), 128'(1'b0));
                    stall_prev = 1'b1;
                    hd  = win_data;
                    hrc = {win_row, win_col};
                end
                if (win_valid && win_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_window: got row %0d col %0d data %0h, want none",
                                 win_row, win_col, win_data);
                    end else begin
                        w = sb_q.pop_front();
                        chk("win_data", 128'(win_data), 128'(w.data));
                        chk("win_row", 128'(win_row), 128'(w.row));
                        chk("win_col", 128'(win_col), 128'(w.col));
                    end
                end
            end
        end
    end

    // Monitor for the 3x3 instance (downstream always ready).
    initial begin
        win_t w;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && win_valid_b) begin
                if (sb_b.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL b_unexpected_window: got data %0h, want none", win_data_b);
                end else begin
                    w = sb_b.pop_front();
                    chk("b_win_data", 128'(win_data_b), 128'(w.data));
                    chk("b_win_rowcol", 128'({win_row_b, win_col_b}), 128'(0));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [7:0] pix [9];
        win_t wb;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_win_valid", 128'(win_valid), 128'(1'b0));
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset_win_data", 128'(win_data), 128'(0));
        chk("reset_rowcol", 128'({win_row, win_col}), 128'(0));
        chk("reset_frame_done", 128'(frame_done), 128'(1'b0));
        rst_n = 1'b1;

        // Ramp frame, downstream always ready.
        rdy_mode = 0;
        send_frame(0, 1'b0);
        drain();

        // Same ramp with win_ready toggling every cycle.
        rdy_mode = 1;
        send_frame(0, 1'b0);
        drain();

        // Two frames back to back, no idle cycle between them.
        rdy_mode = 0;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        drain();

        // clr together with a pixel at (2,1), then a fresh frame.
        for (int i = 0; i < 9; i++) send(8'(i));
        step(1'b1, 8'd99, 1'b1, acc);
        send_frame(0, 1'b1);
        drain();

        // Random data under random backpressure.
        rdy_mode = 2;
        send_frame(0, 1'b1);
        send_frame(0, 1'b1);
        drain();

        // Asynchronous reset while a window is stalled at the output.
        rdy_mode = 0;
        for (int i = 0; i < 11; i++) send(8'(i));
        rdy_mode = 3;
        idle(1);
        chk("pre_reset_win_valid", 128'(win_valid), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_win_valid", 128'(win_valid), 128'(1'b0));
        chk("async_reset_win_data", 128'(win_data), 128'(0));
        chk("async_reset_rowcol", 128'({win_row, win_col}), 128'(0));
        chk("async_reset_frame_done", 128'(frame_done), 128'(1'b0));
        chk("async_reset_in_ready", 128'(in_ready), 128'(1'b1));
        sb_q.delete();
        stall_prev = 1'b0;
        fd_prev = 1'b0;
        acc_last = 1'b0;
        mr = 0;
        mc = 0;
        #2;
        rst_n = 1'b1;
        rdy_mode = 0;
        send_frame(0, 1'b1);
        drain();

        // 3x3 image: each 9-pixel frame yields one window at (0,0).
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                pix[i] = 8'($urandom_range(0, 255));
                in_valid_b = 1'b1;
                in_data_b  = pix[i];
                #1;
                chk("b_in_ready", 128'(in_ready_b), 128'(1'b1));
            end
            wb.data = '0;
            for (int k = 0; k < 9; k++) wb.data[k*8 +: 8] = pix[k];
            wb.row = 0;
            wb.col = 0;
            sb_b.push_back(wb);
        end
        @(negedge clk);
        in_valid_b = 1'b0;
        #1;
        chk("b_frame_done", 128'(frame_done_b), 128'(1'b1));
        repeat (4) @(negedge clk);
        #3;
        chk("b_leftover_windows", 128'(sb_b.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

- Streaming 3x3 sliding-window generator for the convolution datapath.
- Consumes a raster-order pixel stream of one feature-map channel and emits every fully populated 3x3 window with its output coordinates. Valid convolution, no padding.
- Sits directly upstream of the convolution MAC stage, which consumes one window per handshake.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 8, pixels per row; legal range 3..1024.
- IMG_H, 8, rows per frame; legal range 3..1024.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame restart, single-cycle pulse.
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_data  in  DATA_W  pixel value.
- win_valid  out  1  window present.
- win_ready  in  1  downstream accepts window.
- win_data  out  9*DATA_W  window; element (r,c) at [(r*3+c)*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 is the leftmost column.
- win_row  out  $clog2(IMG_H)  output row index, 0..IMG_H-3.
- win_col  out  $clog2(IMG_W)  output column index, 0..IMG_W-3.
- frame_done  out  1  one-cycle pulse the cycle after the last pixel of a frame is accepted.

## Operation
- Counters: in_col (0..IMG_W-1) and in_row (0..IMG_H-1).
  - Both advance on each accepted pixel.
  - in_col wraps to 0 and in_row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done pulses.
- Two cascaded line buffers, each an IMG_W-deep delay line. They advance only on accepted pixels and supply the pixel from the same column one row up and two rows up.
- Window register: 3x3 array that shifts left by one column per accepted pixel. The new right column is {line2_out, line1_out, in_data}.
- Emission: an accepted pixel with in_row>=2 and in_col>=2 completes a window.
  - Next cycle: win_valid=1, win_data holds the window.
  - win_row = in_row-2, win_col = in_col-2, both taken at acceptance.
- Pixels that do not complete a window produce no output.
- Windows per frame: (IMG_H-2)*(IMG_W-2), emitted in raster order.
- Backpressure:
  - One output register. in_ready = !win_valid || win_ready.
  - win_data, win_row and win_col hold stable while win_valid && !win_ready.
  - win_valid drops after a handshake unless a new window is loaded in the same cycle.
- clr:
  - Zeroes in_row and in_col and clears win_valid.
  - Takes priority over a same-cycle pixel acceptance; that pixel is dropped.
  - Line buffer contents remain but are never emitted, because every window needs two fresh rows.
- rst_n low, asynchronous: counters 0, win_valid 0, win_data 0, win_row 0, win_col 0, frame_done 0. in_ready is 1 after reset. Line buffer and window storage are not reset.
- Reset mid-frame abandons the frame. The next accepted pixel is treated as (0,0).

## Timing
- Latency: pixel acceptance to win_valid is 1 cycle.
- Throughput: 1 pixel/cycle sustained with win_ready held high.
- Stall: when the output is full and win_ready=0, in_ready is low combinationally in the same cycle.
- Simultaneous output handshake and new window: the new window is loaded and win_valid stays 1.
- Frame boundary: the first pixel of the next frame may be accepted the cycle after the last pixel of the current frame. No bubble.
- frame_done: asserted exactly one cycle, independent of win_ready.

## Structure
- Shared cnn_pkg holds:
  - KERNEL = 3;
  - the default DATA_W;
  - function win_idx(r,c) returning r*3+c, used by this block and the MAC stage for unpacking.
- One sub-module, line_buffer:
  - parameterised DATA_W and DEPTH;
  - circular RAM with a single wrapping pointer, enable-driven;
  - read-before-write, giving a delay of exactly DEPTH accepted samples.
- Instantiated twice.

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15 streamed with win_ready=1:
  - exactly 4 windows;
  - first window (0,0) = {0,1,2,4,5,6,8,9,10};
  - last window (1,1) = {5,6,7,9,10,11,13,14,15};
  - frame_done one cycle after pixel 15 is accepted.
- Same stream with win_ready toggling 0/1 every other cycle: identical window sequence; win_data stable while stalled; in_ready low whenever win_valid && !win_ready.
- Two frames back-to-back (pixels 0..15 then 100..115) with no idle cycle: second frame's first window = {100,101,102,104,105,106,108,109,110}; no window mixing the two frames.
- clr asserted together with a valid pixel at (2,1):
  - the pixel is dropped and counters go to 0;
  - a fresh 16-pixel frame yields exactly 4 correct windows.
- rst_n pulsed low mid-frame while win_valid=1:
  - all outputs go to 0 immediately;
  - after release, a new frame produces correct windows starting at (0,0).
- IMG_W=3, IMG_H=3: 9 pixels produce exactly one window at (0,0).
